// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared definitions for the sequential ALU core: opcode values, FSM state
//   encoding and the bit positions of the {Z,N,C,V} flag vector.
//   No ports; imported by alu_seq_core and alu_shift_add_mul.
package alu_seq_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOTA = 4'd5;
   localparam logic [3:0] OP_SHL  = 4'd6;
   localparam logic [3:0] OP_SHR  = 4'd7;
   localparam logic [3:0] OP_SRA  = 4'd8;
   localparam logic [3:0] OP_MUL  = 4'd9;
   localparam logic [3:0] OP_CMP  = 4'd10;
   localparam logic [3:0] OP_PASS = 4'd11;

   typedef enum logic [1:0] {
      S_A   = 2'd0,
      S_B   = 2'd1,
      S_OP  = 2'd2,
      S_MUL = 2'd3
   } state_t;

   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                             input logic c, input logic v);
      logic [3:0] f;
      f         = '0;
      f[FLAG_Z] = z;
      f[FLAG_N] = n;
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/alu_shift_add_mul.sv
// alu_shift_add_mul
//   Unsigned WIDTH x WIDTH shift-add multiplier, one partial product per cycle.
//   Ports:
//     clk, reset   clock, asynchronous active-low reset
//     start        load a/b and begin (ignored while busy)
//     abort        synchronous abort, returns to idle
//     a, b         multiplicand / multiplier
//     busy         high for the WIDTH step cycles
//     done         high during the final step cycle; product is valid then
//     product      2*WIDTH accumulator value after the current step
module alu_shift_add_mul
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] mcand_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   mplier_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               busy_q;

   // Exposing the post-step value lets the caller capture the result on the
   // last step edge, so the multiply occupies exactly WIDTH cycles.
   assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign product  = acc_next;
   assign busy     = busy_q;
   assign done     = busy_q && (cnt_q == CNT_W'(1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else if (abort) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (start && !busy_q) begin
         mcand_q  <= {{WIDTH{1'b0}}, a};
         mplier_q <= b;
         acc_q    <= '0;
         cnt_q    <= CNT_W'(WIDTH);
         busy_q   <= 1'b1;
      end else if (busy_q) begin
         acc_q    <= acc_next;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1))
            busy_q <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_seq_core.sv
// alu_seq_core
//   Sequential ALU: A, B and the opcode are entered one per go rising edge
//   from data_in/op_sel; result and {Z,N,C,V} flags are registered.
//   Ports:
//     clk, reset          clock, asynchronous active-low reset
//     go                  step request (rising edge = one event)
//     clear               synchronous clear, wins over go
//     data_in, op_sel     operand bus and opcode
//     a_val, b_val        registered operands
//     y_val, flags        registered result and {Z,N,C,V}
//     state               FSM state (0 S_A, 1 S_B, 2 S_OP, 3 S_MUL)
//     busy                high in S_MUL
//     done                one-cycle pulse once a new result is visible
//     err                 last result came from a reserved opcode
module alu_seq_core
   import alu_seq_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter bit ACCUM_MODE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic             clear,
   input  logic [WIDTH-1:0] data_in,
   input  logic [3:0]       op_sel,
   output logic [WIDTH-1:0] a_val,
   output logic [WIDTH-1:0] b_val,
   output logic [WIDTH-1:0] y_val,
   output logic [3:0]       flags,
   output logic [1:0]       state,
   output logic             busy,
   output logic             done,
   output logic             err
);

   state_t             state_q;
   logic [WIDTH-1:0]   a_q, b_q, y_q;
   logic [3:0]         flags_q;
   logic               go_q, done_q, err_q;
   logic               ev;

   logic signed [WIDTH-1:0] a_s;
   logic [WIDTH:0]     sum_ext, diff_ext;
   logic [WIDTH-1:0]   alu_y;
   logic               alu_c, alu_v, alu_err;

   logic               mul_start, mul_busy, mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   logic               res_commit;
   logic [WIDTH-1:0]   res_y;
   logic               res_c, res_v, res_err;

   assign ev        = go & ~go_q;
   assign a_s       = a_q;
   assign mul_start = (state_q == S_OP) && ev && !clear && (op_sel == OP_MUL);

   assign a_val = a_q;
   assign b_val = b_q;
   assign y_val = y_q;
   assign flags = flags_q;
   assign state = state_q;
   assign busy  = (state_q == S_MUL);
   assign done  = done_q;
   assign err   = err_q;

   alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start),
      .abort   (clear),
      .a       (a_q),
      .b       (b_q),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_prod)
   );

   // Single-cycle operation mux. Shifts by B >= WIDTH fall out of the
   // language semantics: 0 for << and >>, sign fill for signed >>>.
   always_comb begin
      alu_y    = '0;
      alu_c    = 1'b0;
      alu_v    = 1'b0;
      alu_err  = 1'b0;
      sum_ext  = {1'b0, a_q} + {1'b0, b_q};
      diff_ext = {1'b0, a_q} - {1'b0, b_q};
      case (op_sel)
         OP_ADD: begin
            alu_y = sum_ext[WIDTH-1:0];
            alu_c = sum_ext[WIDTH];
            alu_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_y[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_SUB: begin
            // The extra bit of the zero-extended difference is the borrow.
            alu_y = diff_ext[WIDTH-1:0];
            alu_c = diff_ext[WIDTH];
            alu_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_y[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_AND:  alu_y = a_q & b_q;
         OP_OR:   alu_y = a_q | b_q;
         OP_XOR:  alu_y = a_q ^ b_q;
         OP_NOTA: alu_y = ~a_q;
         OP_SHL:  alu_y = a_q << b_q;
         OP_SHR:  alu_y = a_q >> b_q;
         OP_SRA:  alu_y = a_s >>> b_q;
         OP_MUL:  alu_y = '0;
         OP_CMP:  alu_y = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
         OP_PASS: alu_y = b_q;
         default: alu_err = 1'b1;
      endcase
   end

   // One result path for both single-cycle ops and the multiply completion.
   always_comb begin
      res_commit = 1'b0;
      res_y      = alu_y;
      res_c      = alu_c;
      res_v      = alu_v;
      res_err    = alu_err;
      if ((state_q == S_OP) && ev && (op_sel != OP_MUL)) begin
         res_commit = 1'b1;
      end else if ((state_q == S_MUL) && mul_done) begin
         res_commit = 1'b1;
         res_y      = mul_prod[WIDTH-1:0];
         res_c      = |mul_prod[2*WIDTH-1:WIDTH];
         res_v      = 1'b0;
         res_err    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_A;
         a_q     <= '0;
         b_q     <= '0;
         y_q     <= '0;
         flags_q <= '0;
         go_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         go_q   <= go;
         done_q <= 1'b0;
         if (clear) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
         end else if (res_commit) begin
            y_q     <= res_y;
            flags_q <= pack_flags(res_y == '0, res_y[WIDTH-1], res_c, res_v);
            err_q   <= res_err;
            done_q  <= 1'b1;
            if (ACCUM_MODE) begin
               a_q     <= res_y;
               state_q <= S_B;
            end else begin
               state_q <= S_A;
            end
         end else begin
            case (state_q)
               S_A: if (ev) begin
                  a_q     <= data_in;
                  state_q <= S_B;
               end
               S_B: if (ev) begin
                  b_q     <= data_in;
                  state_q <= S_OP;
               end
               S_OP: if (ev) state_q <= S_MUL;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alu_seq_core.sv
module tb_alu_seq_core;

   logic       clk;
   logic       reset;
   logic       go0, clear0, go1, clear1;
   logic [7:0] data0, data1;
   logic [3:0] op0, op1;
   logic [7:0] a0, b0, y0, a1, b1, y1;
   logic [3:0] flags0, flags1;
   logic [1:0] state0, state1;
   logic       busy0, done0, err0, busy1, done1, err1;

   int tests;
   int fails;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] op;
      logic [7:0] y;
      logic [3:0] fl;
      logic       er;
   } vec_t;

   vec_t vecs [20];

   alu_seq_core #(.WIDTH(8), .ACCUM_MODE(1'b0)) dut0 (
      .clk(clk), .reset(reset), .go(go0), .clear(clear0), .data_in(data0),
      .op_sel(op0), .a_val(a0), .b_val(b0), .y_val(y0), .flags(flags0),
      .state(state0), .busy(busy0), .done(done0), .err(err0)
   );

   alu_seq_core #(.WIDTH(8), .ACCUM_MODE(1'b1)) dut1 (
      .clk(clk), .reset(reset), .go(go1), .clear(clear1), .data_in(data1),
      .op_sel(op1), .a_val(a1), .b_val(b1), .y_val(y1), .flags(flags1),
      .state(state1), .busy(busy1), .done(done1), .err(err1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One go event on the selected DUT: go high for one edge, then low for one.
   task automatic ev(input int d, input logic [7:0] data, input logic [3:0] op);
      if (d == 0) begin data0 = data; op0 = op; go0 = 1'b1; end
      else        begin data1 = data; op1 = op; go1 = 1'b1; end
      @(negedge clk);
      go0 = 1'b0;
      go1 = 1'b0;
      @(negedge clk);
   endtask

   // Enter A, B, op on dut0 and wait (bounded) for the done pulse.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         output bit got_done);
      int n;
      ev(0, a, 4'd0);
      ev(0, b, 4'd0);
      op0 = op;
      go0 = 1'b1;
      @(negedge clk);
      go0 = 1'b0;
      got_done = 1'b0;
      n = 0;
      while (!done0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      got_done = done0;
   endtask

   initial begin
      bit   gd;
      int   cnt;
      tests  = 0;
      fails  = 0;
      reset  = 1'b0;
      go0 = 1'b0; clear0 = 1'b0; data0 = '0; op0 = '0;
      go1 = 1'b0; clear1 = 1'b0; data1 = '0; op1 = '0;

      vecs[0]  = '{8'h7F, 8'h01, 4'd0,  8'h80, 4'b0101, 1'b0};
      vecs[1]  = '{8'h05, 8'h07, 4'd1,  8'hFE, 4'b0110, 1'b0};
      vecs[2]  = '{8'h0F, 8'h11, 4'd9,  8'hFF, 4'b0100, 1'b0};
      vecs[3]  = '{8'h10, 8'h10, 4'd9,  8'h00, 4'b1010, 1'b0};
      vecs[4]  = '{8'h81, 8'h09, 4'd6,  8'h00, 4'b1000, 1'b0};
      vecs[5]  = '{8'h81, 8'h03, 4'd8,  8'hF0, 4'b0100, 1'b0};
      vecs[6]  = '{8'h81, 8'h09, 4'd8,  8'hFF, 4'b0100, 1'b0};
      vecs[7]  = '{8'h81, 8'h03, 4'd7,  8'h10, 4'b0000, 1'b0};
      vecs[8]  = '{8'hF0, 8'h3C, 4'd2,  8'h30, 4'b0000, 1'b0};
      vecs[9]  = '{8'hF0, 8'h0C, 4'd3,  8'hFC, 4'b0100, 1'b0};
      vecs[10] = '{8'hFF, 8'h0F, 4'd4,  8'hF0, 4'b0100, 1'b0};
      vecs[11] = '{8'h0F, 8'h00, 4'd5,  8'hF0, 4'b0100, 1'b0};
      vecs[12] = '{8'h03, 8'h05, 4'd10, 8'h01, 4'b0000, 1'b0};
      vecs[13] = '{8'h05, 8'h03, 4'd10, 8'h00, 4'b1000, 1'b0};
      vecs[14] = '{8'h12, 8'h34, 4'd11, 8'h34, 4'b0000, 1'b0};
      vecs[15] = '{8'hFF, 8'h01, 4'd0,  8'h00, 4'b1010, 1'b0};
      vecs[16] = '{8'h80, 8'h01, 4'd1,  8'h7F, 4'b0001, 1'b0};
      vecs[17] = '{8'h55, 8'hAA, 4'd13, 8'h00, 4'b1000, 1'b1};
      vecs[18] = '{8'h0F, 8'h0F, 4'd2,  8'h0F, 4'b0000, 1'b0};
      vecs[19] = '{8'h01, 8'h03, 4'd6,  8'h08, 4'b0000, 1'b0};

      repeat (3) @(negedge clk);
      chk("reset_a", a0, 0);
      chk("reset_b", b0, 0);
      chk("reset_y", y0, 0);
      chk("reset_flags", flags0, 0);
      chk("reset_state", state0, 0);
      chk("reset_busy", busy0, 0);
      chk("reset_done", done0, 0);
      chk("reset_err", err0, 0);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 20; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].op, gd);
         chk($sformatf("v%0d_done", i), gd, 1);
         chk($sformatf("v%0d_y", i), y0, vecs[i].y);
         chk($sformatf("v%0d_flags", i), flags0, vecs[i].fl);
         chk($sformatf("v%0d_err", i), err0, vecs[i].er);
         chk($sformatf("v%0d_state", i), state0, 0);
         @(negedge clk);
      end

      // done lasts exactly one cycle for a single-cycle op
      ev(0, 8'h7F, 4'd0);
      ev(0, 8'h01, 4'd0);
      op0 = 4'd0; go0 = 1'b1;
      @(negedge clk);
      go0 = 1'b0;
      chk("add_done_hi", done0, 1);
      chk("add_state_a", state0, 0);
      @(negedge clk);
      chk("add_done_lo", done0, 0);

      // multiply takes 8 busy cycles; extra go edges meanwhile are ignored
      ev(0, 8'h0F, 4'd0);
      ev(0, 8'h11, 4'd0);
      op0 = 4'd9; data0 = 8'hAA; go0 = 1'b1;
      @(negedge clk);
      go0 = 1'b0;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         if (!busy0) break;
         cnt++;
         go0 = ~go0;
         @(negedge clk);
      end
      go0 = 1'b0;
      chk("mul_busy_cycles", cnt, 8);
      chk("mul_done", done0, 1);
      chk("mul_y", y0, 8'hFF);
      chk("mul_a_kept", a0, 8'h0F);
      chk("mul_state", state0, 0);
      @(negedge clk);
      chk("mul_state_idle", state0, 0);

      // clear mid-multiply, with a simultaneous go edge that must be dropped
      ev(0, 8'h0F, 4'd0);
      ev(0, 8'h11, 4'd0);
      op0 = 4'd9; go0 = 1'b1;
      @(negedge clk);
      go0 = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_clear_busy", busy0, 1);
      clear0 = 1'b1; go0 = 1'b1; data0 = 8'h55;
      @(negedge clk);
      clear0 = 1'b0;
      chk("clr_state", state0, 0);
      chk("clr_a", a0, 0);
      chk("clr_b", b0, 0);
      chk("clr_y", y0, 0);
      chk("clr_busy", busy0, 0);
      chk("clr_err", err0, 0);
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (done0) cnt++;
         @(negedge clk);
      end
      go0 = 1'b0;
      chk("clr_no_done", cnt, 0);
      chk("clr_a_still0", a0, 0);
      @(negedge clk);

      // asynchronous reset mid-multiply
      ev(0, 8'h0F, 4'd0);
      ev(0, 8'h11, 4'd0);
      op0 = 4'd9; go0 = 1'b1;
      @(negedge clk);
      go0 = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("rst_state", state0, 0);
      chk("rst_a", a0, 0);
      chk("rst_y", y0, 0);
      chk("rst_busy", busy0, 0);
      @(negedge clk);
      reset = 1'b1;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (done0) cnt++;
         @(negedge clk);
      end
      chk("rst_no_done", cnt, 0);

      // accumulator mode on dut1
      ev(1, 8'h08, 4'd0);
      ev(1, 8'h08, 4'd0);
      ev(1, 8'h00, 4'd0);
      chk("acc_y1", y1, 8'h10);
      chk("acc_a1", a1, 8'h10);
      chk("acc_state1", state1, 1);
      ev(1, 8'h01, 4'd0);
      ev(1, 8'h00, 4'd0);
      chk("acc_y2", y1, 8'h11);
      chk("acc_a2", a1, 8'h11);
      chk("acc_state2", state1, 1);

      // go held high: exactly one event (B entry only)
      data1 = 8'h22; go1 = 1'b1;
      repeat (20) @(negedge clk);
      go1 = 1'b0;
      @(negedge clk);
      chk("hold_state", state1, 2);
      chk("hold_b", b1, 8'h22);
      chk("hold_y", y1, 8'h11);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
